// File: rtl/sample_stream_tx_if.sv
// Sample-in / byte-out bundle between the ADC sample path, this block and the UART.
// master = sample producer and UART side (test harness); slave = sample_stream_tx.
// Widths follow the block parameters so one instance can serve any FIFO depth.
interface sample_stream_tx_if #(
  parameter int FIFO_AW = 3,
  parameter int DECIM_W = 8
);
  logic               enable;
  logic               sample_valid;
  logic [9:0]         sample;
  logic [DECIM_W-1:0] decim;
  logic               tx_busy;
  logic               new_tx_data;
  logic [7:0]         tx_data;
  logic               overflow;
  logic [FIFO_AW:0]   fifo_level;

  modport master (
    output enable, sample_valid, sample, decim, tx_busy,
    input  new_tx_data, tx_data, overflow, fifo_level
  );

  modport slave (
    input  enable, sample_valid, sample, decim, tx_busy,
    output new_tx_data, tx_data, overflow, fifo_level
  );
endinterface

// File: rtl/sample_stream_tx.sv
// Decimates 10-bit samples, buffers them and sends each as a HI/LO byte pair to a UART.
// Latency: kept sample in cycle N -> HI byte strobe in N+3, LO strobe no earlier than N+5.
// Backpressure: tx_busy stalls HI/LO; a full FIFO drops kept samples and sets sticky overflow.
module sample_stream_tx #(
  parameter int FIFO_AW = 3,
  parameter int DECIM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sample_stream_tx_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    GAP1 = 3'd2,
    LO   = 3'd3,
    GAP2 = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Decimation
  logic [DECIM_W-1:0] dcnt;
  logic               keep;

  // FIFO
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push, pop;

  // Packet holding register and sequence tag
  logic [1:0]         seq;
  logic [9:0]         hold_sample;
  logic [1:0]         hold_seq;
  logic [7:0]         hi_byte, lo_byte;

  // Output registers
  logic               new_tx_data_q, new_tx_data_nxt;
  logic [7:0]         tx_data_q, tx_data_nxt;
  logic               overflow_q;

  // A sample is kept when the decimation counter has run down to zero.
  assign keep  = bus.sample_valid & bus.enable & (dcnt == '0);
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // IDLE pops whenever there is a word waiting; this frees a slot the same cycle.
  assign pop   = (state == IDLE) & ~empty;
  assign push  = keep & (~full | pop);

  // HI byte carries the resync marker in bit 7 and the sequence tag.
  assign hi_byte = {1'b1, hold_seq, hold_sample[9:5]};
  assign lo_byte = {3'b000, hold_sample[4:0]};

  // Decimation counter: reload on keep, count down on drop, parked at 0 when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (!bus.enable) begin
      dcnt <= '0;
    end else if (bus.sample_valid) begin
      if (dcnt == '0) begin
        dcnt <= bus.decim;
      end else begin
        dcnt <= dcnt - DECIM_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.sample;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a kept sample that could not be written is lost for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (keep && !push) begin
      overflow_q <= 1'b1;
    end
  end

  // Pop into the holding register, tagging the word with the current sequence number.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq         <= 2'd0;
      hold_sample <= '0;
      hold_seq    <= 2'd0;
    end else if (pop) begin
      hold_sample <= mem[rd_ptr];
      hold_seq    <= seq;
      seq         <= seq + 2'd1;
    end
  end

  // Packet FSM: GAP states give the UART one cycle to raise tx_busy after each strobe.
  always_comb begin
    state_nxt       = state;
    new_tx_data_nxt = 1'b0;
    tx_data_nxt     = tx_data_q;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = HI;
        end
      end
      HI: begin
        if (!bus.tx_busy) begin
          tx_data_nxt     = hi_byte;
          new_tx_data_nxt = 1'b1;
          state_nxt       = GAP1;
        end
      end
      GAP1: begin
        state_nxt = LO;
      end
      LO: begin
        if (!bus.tx_busy) begin
          tx_data_nxt     = lo_byte;
          new_tx_data_nxt = 1'b1;
          state_nxt       = GAP2;
        end
      end
      GAP2: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and registered byte strobe / data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      new_tx_data_q <= 1'b0;
      tx_data_q     <= 8'h00;
    end else begin
      state         <= state_nxt;
      new_tx_data_q <= new_tx_data_nxt;
      tx_data_q     <= tx_data_nxt;
    end
  end

  assign bus.new_tx_data = new_tx_data_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.overflow    = overflow_q;
  assign bus.fifo_level  = count;

endmodule

// File: tb/tb_sample_stream_tx.sv
// Directed bench for sample_stream_tx: table of single-sample packets plus
// hand-written sequences for decimation, stall, overflow, push/pop at full,
// mid-packet reset and enable gating.
module tb_sample_stream_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_stream_tx_if #(.FIFO_AW(3), .DECIM_W(8)) bus ();

  sample_stream_tx #(.FIFO_AW(3), .DECIM_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every byte strobe seen on the UART side, with the cycle it was visible in.
  logic [7:0] strb_q[$];
  int         strb_cyc_q[$];

  always @(negedge clk) begin
    if (bus.new_tx_data === 1'b1) begin
      strb_q.push_back(bus.tx_data);
      strb_cyc_q.push_back(cyc);
    end
  end

  typedef struct {
    logic [9:0] s;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    strb_q.delete();
    strb_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.tx_busy      = 1'b0;
    bus.enable       = 1'b1;
    bus.decim        = 8'd0;
    step();
    step();
    rst = 1'b0;
    clear_strobes();
  endtask

  task automatic send(input logic [9:0] s);
    bus.sample       = s;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_strobes(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (strb_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check({name, "_strobe_count"}, strb_q.size() >= n, 1);
  endtask

  function automatic logic [31:0] byte_at(input int i);
    if (i < strb_q.size()) return {24'h0, strb_q[i]};
    return 32'hDEAD;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < strb_cyc_q.size()) return strb_cyc_q[i];
    return -1;
  endfunction

  initial begin
    int n;
    int cnt;
    int errs;
    logic ok;
    logic [9:0] s;
    logic [7:0] ehi;

    bus.enable       = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.decim        = '0;
    bus.tx_busy      = 1'b0;

    // s, HI = {1, seq, s[9:5]}, LO = {000, s[4:0]}; seq runs 0,1,2,3,0,1
    vecs[0] = '{10'h2A5, 8'h95, 8'h05};
    vecs[1] = '{10'h3FF, 8'hBF, 8'h1F};
    vecs[2] = '{10'h000, 8'hC0, 8'h00};
    vecs[3] = '{10'h155, 8'hEA, 8'h15};
    vecs[4] = '{10'h0E0, 8'h87, 8'h00};
    vecs[5] = '{10'h21F, 8'hB0, 8'h1F};

    // Reset state
    do_reset();
    check("rst_new_tx_data", bus.new_tx_data, 0);
    check("rst_tx_data",     bus.tx_data,     0);
    check("rst_overflow",    bus.overflow,    0);
    check("rst_fifo_level",  bus.fifo_level,  0);

    // Single-sample packets, including byte timing N+3 / N+5
    for (int i = 0; i < 6; i++) begin
      clear_strobes();
      n = cyc;
      send(vecs[i].s);
      wait_strobes($sformatf("vec%0d", i), 2, 20);
      check($sformatf("vec%0d_hi", i), byte_at(0), vecs[i].hi);
      check($sformatf("vec%0d_lo", i), byte_at(1), vecs[i].lo);
      check($sformatf("vec%0d_hi_cyc", i), cyc_at(0), n + 3);
      check($sformatf("vec%0d_lo_cyc", i), cyc_at(1), n + 5);
      step();
      check($sformatf("vec%0d_two_strobes", i), strb_q.size(), 2);
    end
    check("single_overflow", bus.overflow, 0);

    // Decimation: decim=3 over samples 0..11 keeps 0, 4, 8
    do_reset();
    bus.decim = 8'd3;
    for (int i = 0; i < 12; i++) send(10'(i));
    wait_strobes("decim", 6, 100);
    for (int i = 0; i < 20; i++) step();
    check("decim_count", strb_q.size(), 6);
    check("decim_hi0", byte_at(0), 8'h80);
    check("decim_lo0", byte_at(1), 8'h00);
    check("decim_hi1", byte_at(2), 8'hA0);
    check("decim_lo1", byte_at(3), 8'h04);
    check("decim_hi2", byte_at(4), 8'hC0);
    check("decim_lo2", byte_at(5), 8'h08);

    // Handshake stall between HI and LO
    do_reset();
    send(10'h2A5);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.new_tx_data === 1'b1) ok = 1'b1;
      else step();
    end
    check("stall_first_strobe", ok, 1);
    bus.tx_busy = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.new_tx_data !== 1'b0 || bus.tx_data !== 8'h95) errs++;
    end
    check("stall_quiet_and_held", errs, 0);
    bus.tx_busy = 1'b0;
    step();
    check("stall_lo_strobe", bus.new_tx_data, 1);
    check("stall_lo_byte",   bus.tx_data,     8'h05);

    // Overflow: 12 kept samples against a busy UART
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 12; i++) send(10'(i * 37));
    step();
    step();
    check("ovf_level_sat", bus.fifo_level, 8);
    check("ovf_flag",      bus.overflow,   1);
    check("ovf_no_strobe", strb_q.size(),  0);
    bus.tx_busy = 1'b0;
    wait_strobes("ovf_drain", 18, 300);
    for (int i = 0; i < 20; i++) step();
    check("ovf_drain_count", strb_q.size(), 18);
    for (int j = 0; j < 9; j++) begin
      s   = 10'(j * 37);
      ehi = {1'b1, 2'(j % 4), s[9:5]};
      check($sformatf("ovf_hi%0d", j), byte_at(2 * j),     ehi);
      check($sformatf("ovf_lo%0d", j), byte_at(2 * j + 1), {3'b000, s[4:0]});
    end
    check("ovf_sticky",     bus.overflow,   1);
    check("ovf_level_zero", bus.fifo_level, 0);

    // Push in the same cycle IDLE pops a full FIFO
    do_reset();
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) send(10'h300 + 10'(i));
    step();
    check("pp_level_full", bus.fifo_level, 8);
    bus.tx_busy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      step();
      if (bus.new_tx_data === 1'b1) cnt++;
    end
    check("pp_packet_done", cnt, 2);
    step();
    check("pp_in_idle",      32'(dut.state),  0);
    check("pp_full_at_idle", bus.fifo_level, 8);
    send(10'h3AB);
    check("pp_level_kept",   bus.fifo_level, 8);
    check("pp_no_overflow",  bus.overflow,   0);

    // Mid-packet reset in GAP1 with a second word queued
    do_reset();
    bus.sample       = 10'h111;
    bus.sample_valid = 1'b1;
    step();
    bus.sample       = 10'h222;
    step();
    bus.sample_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.new_tx_data === 1'b1) ok = 1'b1;
      else step();
    end
    check("mrst_hi_seen", ok, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_strobes();
    check("mrst_state_idle", 32'(dut.state), 0);
    check("mrst_level",      bus.fifo_level, 0);
    check("mrst_strobe",     bus.new_tx_data, 0);
    for (int i = 0; i < 30; i++) step();
    check("mrst_no_more_bytes", strb_q.size(), 0);

    // Enable gating
    do_reset();
    bus.decim = 8'd2;
    send(10'h0AA);
    wait_strobes("en_first", 2, 20);
    check("en_dcnt_loaded", dut.dcnt, 2);
    step();
    clear_strobes();
    bus.enable = 1'b0;
    send(10'h001);
    send(10'h002);
    send(10'h003);
    check("en_dcnt_forced", dut.dcnt, 0);
    for (int i = 0; i < 20; i++) step();
    check("en_no_traffic", strb_q.size(),  0);
    check("en_no_level",   bus.fifo_level, 0);
    bus.enable = 1'b1;
    send(10'h3C1);
    wait_strobes("en_resume", 2, 20);
    check("en_resume_hi", byte_at(0), 8'hBE);
    check("en_resume_lo", byte_at(1), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: never let the run hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/sample_stream_tx.md
# sample_stream_tx

Downstream consumer of the ADC sample path. Accepts validated 10-bit samples, optionally decimates them, buffers them in a small FIFO and streams each one as a self-framing two-byte packet to the serial transmitter through its `new_tx_data`/`tx_busy` handshake. The block decouples the bursty sample rate from the slow UART byte rate and flags any samples lost to overflow.

## Interface
- `FIFO_AW`, default 3: FIFO address width; depth = 2^FIFO_AW words (8).
- `DECIM_W`, default 8: width of the decimation control input.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: streaming enable; gates sample acceptance only.
- `sample_valid`, in, 1: one-cycle strobe; `sample` is valid.
- `sample`, in, 10: processed sample value.
- `decim`, in, DECIM_W: keep one sample, then drop the next `decim` samples.
- `tx_busy`, in, 1: serial transmitter busy.
- `new_tx_data`, out, 1: registered one-cycle byte strobe.
- `tx_data`, out, 8: byte to transmit; held until the next strobe.
- `overflow`, out, 1: sticky; set when a kept sample is dropped because the FIFO is full.
- `fifo_level`, out, FIFO_AW+1: current FIFO occupancy, 0..2^FIFO_AW.

## Operation
- Reset values: `new_tx_data`=0, `tx_data`=0, `overflow`=0, `fifo_level`=0. The decimation counter, the 2-bit sequence counter and the FIFO pointers all reset to 0. The FSM resets to IDLE.
- **Decimation.** On `sample_valid & enable`:
  - if `dcnt`==0, the sample is kept (pushed) and `dcnt` <= `decim`;
  - otherwise the sample is dropped and `dcnt` <= `dcnt`-1.
- With `decim`=0, every sample is kept. `decim` is sampled only at a keep event.
- While `enable`=0: `dcnt` is forced to 0 and nothing is pushed. The FIFO keeps draining.
- **FIFO.** Synchronous, first-word-fall-through not required.
  - A push is accepted when not full, or when a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow` <= 1. `overflow` clears only on `rst`.
  - Pointers wrap modulo depth.
- **Packet format** for sample s, with seq = sequence counter value at pop:
  - HI byte = {1, seq[1:0], s[9:5]}.
  - LO byte = {000, s[4:0]}.
  - Bit 7 marks HI bytes for receiver resync. `seq` increments (mod 4) on each pop.
- **FSM states:**
  - IDLE: if FIFO non-empty, pop the word into a holding register and go to HI.
  - HI: if `tx_busy`=0, set `tx_data`<=HI byte and `new_tx_data`<=1, then go to GAP1. Otherwise stay in HI.
  - GAP1: `new_tx_data`<=0 (one-cycle hold-off so the transmitter can raise `tx_busy`); go to LO.
  - LO: if `tx_busy`=0, set `tx_data`<=LO byte and `new_tx_data`<=1, then go to GAP2. Otherwise stay in LO.
  - GAP2: `new_tx_data`<=0; go to IDLE.
- `new_tx_data` is high in GAP1 and GAP2 cycles only, never for 2 consecutive cycles.
- `rst` mid-packet returns the FSM to IDLE and discards the FIFO contents and the holding register. No partial-packet completion.

## Timing
- Sample strobe in cycle N (kept, FIFO empty, IDLE, `tx_busy`=0):
  - FIFO write at end of N;
  - pop in N+1;
  - HI decision in N+2;
  - `new_tx_data`=1 with HI byte in N+3.
- LO strobe follows no earlier than N+5. The HI-to-LO strobe spacing is at least 2 cycles plus however long `tx_busy` stays high.
- Minimum packet period with an idle UART is 5 cycles. With a real UART it is 2 byte times.
- `fifo_level` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `tx_busy` is ignored outside the HI and LO states.

## Test plan
- **Single sample.** Apply `rst`, then `decim`=0, `enable`=1, one strobe with `sample`=10'h2A5 and `tx_busy` tied 0.
  - Expect exactly two strobes: `tx_data`=0x95, then 0x05.
  - First strobe in cycle N+3, second in N+5. `overflow`=0.
- **Decimation.** Set `decim`=3 and apply 12 back-to-back strobes with values 0..11.
  - Exactly samples 0, 4, 8 are transmitted.
  - HI bytes are 0x80, 0xA0, 0xC0 (seq 0, 1, 2). LO bytes are 0x00, 0x04, 0x08.
- **Handshake stall.** Hold `tx_busy`=1 for 20 cycles after the first strobe.
  - No second strobe during the stall.
  - LO strobe occurs 1 cycle after `tx_busy` falls (LO→GAP2). `tx_data` is held throughout.
- **Overflow.** Hold `tx_busy`=1 and push 12 kept samples.
  - `fifo_level` saturates at 8. One word sits in the holding register, so 3 samples are dropped.
  - `overflow`=1 and stays 1 after the drain.
  - The 9 surviving samples come out in order with seq wrapping 0,1,2,3,0,...
- **Simultaneous push/pop at full.** Fill the FIFO, then strobe a sample in the cycle IDLE pops.
  - The push is accepted, `fifo_level` stays 8 and `overflow` stays 0.
- **Mid-packet reset and enable gating.**
  - Assert `rst` in GAP1: next cycle the FSM is in IDLE, `fifo_level`=0, `new_tx_data`=0, and no LO byte is ever sent.
  - With `enable`=0, strobes produce no traffic and `dcnt` reads 0.
